// File: rtl/rca_config_pkg.sv
// rca_config_pkg: RCA geometry, config opcodes and the held config instruction type
package rca_config_pkg;
   localparam int NUM_RCAS        = 4;
   localparam int NUM_READ_PORTS  = 5;
   localparam int NUM_WRITE_PORTS = 5;
   localparam int NUM_GRID_MUXES  = 72;
   localparam int NUM_IO_UNITS    = 13;
   localparam int REG_ADDR_W      = 5;
   localparam int GRID_SEL_W      = 3;
   localparam int IO_SEL_W        = 4;
   localparam int RES_SEL_W       = 4;
   localparam logic [RES_SEL_W-1:0] UNUSED_WRITE_PORT_ADDR = 4'd13;
   localparam logic [2:0] RCA_USE_FB   = 3'b000;
   localparam logic [2:0] CPU_REG_CFG  = 3'b001;
   localparam logic [2:0] GRID_MUX_CFG = 3'b010;
   localparam logic [2:0] IO_MUX_CFG   = 3'b011;
   localparam logic [2:0] RES_MUX_CFG  = 3'b100;
   localparam logic [2:0] IO_USE_CFG   = 3'b101;
   localparam logic [2:0] RCA_USE_NFB  = 3'b110;
   typedef struct packed {
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } rca_cfg_instr_t;
endpackage

// File: rtl/rca_config_legality.sv
// rca_config_legality: combinational legality check of a held config instruction
module rca_config_legality
   import rca_config_pkg::*;
(
   input  rca_cfg_instr_t instr,
   output logic           illegal
);
   logic [31:0] port;
   logic        bad_id, bad_op, bad_arg;
   assign port   = 32'(instr.rs1[2:0]);
   assign bad_id = 32'(instr.funct7) >= NUM_RCAS;
   assign bad_op = instr.funct3 == RCA_USE_FB || instr.funct3 == RCA_USE_NFB || instr.funct3 == 3'b111;
   always_comb begin
      bad_arg = instr.funct3 == CPU_REG_CFG  ? (instr.rs1[3] ? port >= NUM_WRITE_PORTS : port >= NUM_READ_PORTS) :
                instr.funct3 == GRID_MUX_CFG ? (instr.rs1 >= NUM_GRID_MUXES || instr.rs2 >= 8) :
                instr.funct3 == IO_MUX_CFG   ? (instr.rs1 >= NUM_IO_UNITS || instr.rs2 >= 12) :
                instr.funct3 == RES_MUX_CFG  ? (port >= NUM_WRITE_PORTS || instr.rs2 > 13) :
                1'b0;
   end
   assign illegal = bad_id || bad_op || bad_arg;
endmodule

// File: rtl/rca_config_unit.sv
// rca_config_unit: executes RCA config instructions and holds every per-RCA config register,
// deferring each write until its target RCA is idle.
module rca_config_unit
   import rca_config_pkg::*;
(
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           issue_valid,
   output logic                                           issue_ready,
   input  logic [2:0]                                     issue_funct3,
   input  logic [6:0]                                     issue_funct7,
   input  logic [31:0]                                    issue_rs1,
   input  logic [31:0]                                    issue_rs2,
   input  logic [NUM_RCAS-1:0]                            rca_busy,
   input  logic                                           flush,
   output logic                                           cfg_done,
   output logic                                           cfg_err,
   output logic [NUM_RCAS-1:0]                            cfg_changed,
   output logic [NUM_RCAS*NUM_READ_PORTS*REG_ADDR_W-1:0]  src_addr,
   output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0] dst_addr_fb,
   output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0] dst_addr_nfb,
   output logic [NUM_RCAS*NUM_GRID_MUXES*GRID_SEL_W-1:0]  grid_sel,
   output logic [NUM_RCAS*NUM_IO_UNITS*IO_SEL_W-1:0]      io_sel,
   output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_SEL_W-1:0]  res_sel_fb,
   output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_SEL_W-1:0]  res_sel_nfb,
   output logic [NUM_RCAS*NUM_IO_UNITS-1:0]               io_use
);
   typedef enum logic [1:0] {IDLE, CHECK, WAIT} state_t;
   state_t         state;
   rca_cfg_instr_t h;
   logic           illegal, busy_t, commit;
   logic           wr_src, wr_dfb, wr_dnfb, wr_grid, wr_io, wr_rfb, wr_rnfb, wr_use;
   logic [NUM_RCAS-1:0] hit;
   logic [REG_ADDR_W-1:0] src_q  [NUM_RCAS][NUM_READ_PORTS];
   logic [REG_ADDR_W-1:0] dfb_q  [NUM_RCAS][NUM_WRITE_PORTS];
   logic [REG_ADDR_W-1:0] dnfb_q [NUM_RCAS][NUM_WRITE_PORTS];
   logic [GRID_SEL_W-1:0] grid_q [NUM_RCAS][NUM_GRID_MUXES];
   logic [IO_SEL_W-1:0]   io_q   [NUM_RCAS][NUM_IO_UNITS];
   logic [RES_SEL_W-1:0]  rfb_q  [NUM_RCAS][NUM_WRITE_PORTS];
   logic [RES_SEL_W-1:0]  rnfb_q [NUM_RCAS][NUM_WRITE_PORTS];
   logic [NUM_IO_UNITS-1:0] use_q [NUM_RCAS];
   rca_config_legality u_legality (.instr(h), .illegal(illegal));
   // Only the target RCA's busy bit may stall the write
   always_comb begin
      busy_t = 1'b0;
      for (int r = 0; r < NUM_RCAS; r++) busy_t = 32'(h.funct7) == r ? rca_busy[r] : busy_t;
   end
   assign issue_ready = state == IDLE;
   assign commit      = !flush && !busy_t && (state == WAIT || (state == CHECK && !illegal));
   assign cfg_err     = state == CHECK && !flush && illegal;
   assign cfg_done    = commit || cfg_err;
   assign wr_src  = h.funct3 == CPU_REG_CFG && !h.rs1[3];
   assign wr_dfb  = h.funct3 == CPU_REG_CFG && h.rs1[3] && h.rs1[4];
   assign wr_dnfb = h.funct3 == CPU_REG_CFG && h.rs1[3] && !h.rs1[4];
   assign wr_grid = h.funct3 == GRID_MUX_CFG;
   assign wr_io   = h.funct3 == IO_MUX_CFG;
   assign wr_rfb  = h.funct3 == RES_MUX_CFG && h.rs1[3];
   assign wr_rnfb = h.funct3 == RES_MUX_CFG && !h.rs1[3];
   assign wr_use  = h.funct3 == IO_USE_CFG;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         h           <= '0;
         cfg_changed <= '0;
      end else begin
         if (issue_valid && issue_ready)
            h <= '{funct3: issue_funct3, funct7: issue_funct7, rs1: issue_rs1, rs2: issue_rs2};
         state <= state == IDLE  ? (issue_valid ? CHECK : IDLE) :
                  state == CHECK ? (!flush && !illegal && busy_t ? WAIT : IDLE) :
                  state == WAIT  ? (!flush && busy_t ? WAIT : IDLE) : IDLE;
         cfg_changed <= hit;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q  <= '{default: '0};
         dfb_q  <= '{default: '0};
         dnfb_q <= '{default: '0};
         grid_q <= '{default: '0};
         io_q   <= '{default: '0};
         rfb_q  <= '{default: UNUSED_WRITE_PORT_ADDR};
         rnfb_q <= '{default: UNUSED_WRITE_PORT_ADDR};
         use_q  <= '{default: '0};
      end else begin
         for (int r = 0; r < NUM_RCAS; r++) begin
            for (int p = 0; p < NUM_READ_PORTS; p++)
               if (hit[r] && wr_src && h.rs1[2:0] == 3'(p)) src_q[r][p] <= h.rs2[REG_ADDR_W-1:0];
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
               if (hit[r] && wr_dfb && h.rs1[2:0] == 3'(p)) dfb_q[r][p] <= h.rs2[REG_ADDR_W-1:0];
               if (hit[r] && wr_dnfb && h.rs1[2:0] == 3'(p)) dnfb_q[r][p] <= h.rs2[REG_ADDR_W-1:0];
               if (hit[r] && wr_rfb && h.rs1[2:0] == 3'(p)) rfb_q[r][p] <= h.rs2[RES_SEL_W-1:0];
               if (hit[r] && wr_rnfb && h.rs1[2:0] == 3'(p)) rnfb_q[r][p] <= h.rs2[RES_SEL_W-1:0];
            end
            for (int g = 0; g < NUM_GRID_MUXES; g++)
               if (hit[r] && wr_grid && h.rs1 == 32'(g)) grid_q[r][g] <= h.rs2[GRID_SEL_W-1:0];
            for (int u = 0; u < NUM_IO_UNITS; u++)
               if (hit[r] && wr_io && h.rs1 == 32'(u)) io_q[r][u] <= h.rs2[IO_SEL_W-1:0];
            if (hit[r] && wr_use) use_q[r] <= h.rs1[NUM_IO_UNITS-1:0];
         end
      end
   end
   // Flatten the per-RCA register arrays onto the configuration buses
   for (genvar r = 0; r < NUM_RCAS; r++) begin : g_rca
      assign hit[r] = commit && h.funct7 == 7'(r);
      assign io_use[r*NUM_IO_UNITS +: NUM_IO_UNITS] = use_q[r];
      for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
         assign src_addr[(r*NUM_READ_PORTS+p)*REG_ADDR_W +: REG_ADDR_W] = src_q[r][p];
      end
      for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_wr
         assign dst_addr_fb[(r*NUM_WRITE_PORTS+p)*REG_ADDR_W +: REG_ADDR_W]  = dfb_q[r][p];
         assign dst_addr_nfb[(r*NUM_WRITE_PORTS+p)*REG_ADDR_W +: REG_ADDR_W] = dnfb_q[r][p];
         assign res_sel_fb[(r*NUM_WRITE_PORTS+p)*RES_SEL_W +: RES_SEL_W]     = rfb_q[r][p];
         assign res_sel_nfb[(r*NUM_WRITE_PORTS+p)*RES_SEL_W +: RES_SEL_W]    = rnfb_q[r][p];
      end
      for (genvar g = 0; g < NUM_GRID_MUXES; g++) begin : g_grid
         assign grid_sel[(r*NUM_GRID_MUXES+g)*GRID_SEL_W +: GRID_SEL_W] = grid_q[r][g];
      end
      for (genvar u = 0; u < NUM_IO_UNITS; u++) begin : g_io
         assign io_sel[(r*NUM_IO_UNITS+u)*IO_SEL_W +: IO_SEL_W] = io_q[r][u];
      end
   end
endmodule

// File: tb/tb_rca_config_unit.sv
// tb_rca_config_unit: randomized and directed checks of rca_config_unit against an
// array-based model of the configuration registers.
module tb_rca_config_unit;
   import rca_config_pkg::*;
   localparam int SW = NUM_RCAS*NUM_READ_PORTS*5;
   localparam int DW = NUM_RCAS*NUM_WRITE_PORTS*5;
   localparam int GW = NUM_RCAS*NUM_GRID_MUXES*3;
   localparam int IW = NUM_RCAS*NUM_IO_UNITS*4;
   localparam int RW = NUM_RCAS*NUM_WRITE_PORTS*4;
   localparam int UW = NUM_RCAS*NUM_IO_UNITS;
   localparam int TW = SW + 2*DW + GW + IW + 2*RW + UW;

   logic clk = 0, rst_n = 0, issue_valid = 0, flush = 0;
   logic issue_ready, cfg_done, cfg_err;
   logic [2:0] issue_funct3 = '0;
   logic [6:0] issue_funct7 = '0;
   logic [31:0] issue_rs1 = '0, issue_rs2 = '0;
   logic [NUM_RCAS-1:0] rca_busy = '0, cfg_changed;
   logic [SW-1:0] src_addr;
   logic [DW-1:0] dst_addr_fb, dst_addr_nfb;
   logic [GW-1:0] grid_sel;
   logic [IW-1:0] io_sel;
   logic [RW-1:0] res_sel_fb, res_sel_nfb;
   logic [UW-1:0] io_use;
   logic [TW-1:0] act_all, exp_v;
   int passed = 0, total = 0;

   logic [4:0]  m_src  [NUM_RCAS][NUM_READ_PORTS];
   logic [4:0]  m_dfb  [NUM_RCAS][NUM_WRITE_PORTS];
   logic [4:0]  m_dnfb [NUM_RCAS][NUM_WRITE_PORTS];
   logic [2:0]  m_grid [NUM_RCAS][NUM_GRID_MUXES];
   logic [3:0]  m_io   [NUM_RCAS][NUM_IO_UNITS];
   logic [3:0]  m_rfb  [NUM_RCAS][NUM_WRITE_PORTS];
   logic [3:0]  m_rnfb [NUM_RCAS][NUM_WRITE_PORTS];
   logic [12:0] m_use  [NUM_RCAS];

   rca_config_unit dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_funct3(issue_funct3), .issue_funct7(issue_funct7), .issue_rs1(issue_rs1),
      .issue_rs2(issue_rs2), .rca_busy(rca_busy), .flush(flush), .cfg_done(cfg_done),
      .cfg_err(cfg_err), .cfg_changed(cfg_changed), .src_addr(src_addr),
      .dst_addr_fb(dst_addr_fb), .dst_addr_nfb(dst_addr_nfb), .grid_sel(grid_sel),
      .io_sel(io_sel), .res_sel_fb(res_sel_fb), .res_sel_nfb(res_sel_nfb), .io_use(io_use));

   always #5 clk = ~clk;
   assign act_all = {src_addr, dst_addr_fb, dst_addr_nfb, grid_sel, io_sel, res_sel_fb, res_sel_nfb, io_use};

   task automatic model_reset();
      for (int r = 0; r < NUM_RCAS; r++) begin
         m_use[r] = '0;
         for (int p = 0; p < 5; p++) begin
            m_src[r][p] = '0; m_dfb[r][p] = '0; m_dnfb[r][p] = '0; m_rfb[r][p] = 4'd13; m_rnfb[r][p] = 4'd13;
         end
         for (int g = 0; g < NUM_GRID_MUXES; g++) m_grid[r][g] = '0;
         for (int u = 0; u < NUM_IO_UNITS; u++) m_io[r][u] = '0;
      end
   endtask

   function automatic bit legal(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, b);
      if (f7 >= 7'd4) return 0;
      case (f3)
         3'd1: return a[3] ? a[2:0] < 3'd5 : a[2:0] < 3'd5;
         3'd2: return a < 72 && b < 8;
         3'd3: return a < 13 && b < 12;
         3'd4: return a[2:0] < 3'd5 && b <= 13;
         3'd5: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic model_apply(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, b);
      case (f3)
         3'd1: if (!a[3]) m_src[f7][a[2:0]] = b[4:0];
               else if (a[4]) m_dfb[f7][a[2:0]] = b[4:0];
               else m_dnfb[f7][a[2:0]] = b[4:0];
         3'd2: m_grid[f7][a] = b[2:0];
         3'd3: m_io[f7][a] = b[3:0];
         3'd4: if (a[3]) m_rfb[f7][a[2:0]] = b[3:0]; else m_rnfb[f7][a[2:0]] = b[3:0];
         3'd5: m_use[f7] = a[12:0];
         default: ;
      endcase
   endtask

   // Shifting in from the highest entry downward yields the bus concatenation order
   function automatic logic [TW-1:0] expected();
      logic [TW-1:0] e = '0;
      for (int r = NUM_RCAS-1; r >= 0; r--) for (int p = 4; p >= 0; p--) e = (e << 5) | TW'(m_src[r][p]);
      for (int r = NUM_RCAS-1; r >= 0; r--) for (int p = 4; p >= 0; p--) e = (e << 5) | TW'(m_dfb[r][p]);
      for (int r = NUM_RCAS-1; r >= 0; r--) for (int p = 4; p >= 0; p--) e = (e << 5) | TW'(m_dnfb[r][p]);
      for (int r = NUM_RCAS-1; r >= 0; r--) for (int g = NUM_GRID_MUXES-1; g >= 0; g--) e = (e << 3) | TW'(m_grid[r][g]);
      for (int r = NUM_RCAS-1; r >= 0; r--) for (int u = NUM_IO_UNITS-1; u >= 0; u--) e = (e << 4) | TW'(m_io[r][u]);
      for (int r = NUM_RCAS-1; r >= 0; r--) for (int p = 4; p >= 0; p--) e = (e << 4) | TW'(m_rfb[r][p]);
      for (int r = NUM_RCAS-1; r >= 0; r--) for (int p = 4; p >= 0; p--) e = (e << 4) | TW'(m_rnfb[r][p]);
      for (int r = NUM_RCAS-1; r >= 0; r--) e = (e << 13) | TW'(m_use[r]);
      return e;
   endfunction

   function automatic int first_diff(input logic [TW-1:0] a, b);
      for (int i = 0; i < TW; i++) if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   task automatic run_instr(input string name, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] a, b, input int stall);
      bit ok = legal(f3, f7, a, b);
      logic [NUM_RCAS-1:0] tm = f7 < 7'(NUM_RCAS) ? NUM_RCAS'(1) << f7 : '0;
      int d;
      @(negedge clk);
      issue_valid = 1; issue_funct3 = f3; issue_funct7 = f7; issue_rs1 = a; issue_rs2 = b;
      #1;
      total++; if (issue_ready !== 1'b1) $display("FAIL %s ready: got %b want 1", name, issue_ready); else passed++;
      @(negedge clk);
      issue_valid = 0;
      for (int i = 0; i < stall && ok; i++) begin
         rca_busy = tm | (NUM_RCAS'($urandom) & ~tm);
         #1;
         total++; if (cfg_done !== 1'b0) $display("FAIL %s stall%0d: cfg_done got %b want 0", name, i, cfg_done); else passed++;
         @(negedge clk);
      end
      rca_busy = ok ? NUM_RCAS'($urandom) & ~tm : NUM_RCAS'($urandom);
      #1;
      total++;
      if ({cfg_done, cfg_err} !== {1'b1, !ok}) $display("FAIL %s done/err: got %b%b want 1%b", name, cfg_done, cfg_err, !ok);
      else passed++;
      if (ok) model_apply(f3, f7, a, b);
      @(negedge clk);
      rca_busy = '0;
      #1;
      total++;
      if (cfg_changed !== (ok ? tm : '0)) $display("FAIL %s changed: got %b want %b", name, cfg_changed, ok ? tm : '0);
      else passed++;
      exp_v = expected(); d = first_diff(act_all, exp_v);
      total++;
      if (act_all !== exp_v) $display("FAIL %s buses: bit %0d got %b want %b", name, d, act_all[d], exp_v[d]);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      model_reset();
      #1;
      exp_v = expected();
      total++; if (act_all !== exp_v) $display("FAIL reset buses: bit %0d differs", first_diff(act_all, exp_v)); else passed++;
      total++; if (res_sel_fb[3:0] !== 4'd13) $display("FAIL reset res_sel_fb0: got %0d want 13", res_sel_fb[3:0]); else passed++;
      total++;
      if ({issue_ready, cfg_done, cfg_err, cfg_changed} !== {1'b1, 6'b0})
         $display("FAIL reset ctrl: got %b want 1000000", {issue_ready, cfg_done, cfg_err, cfg_changed});
      else passed++;
      rst_n = 1;
   endtask

   task automatic test_basic();
      run_instr("src_write", 3'b001, 7'd2, 32'h3, 32'd7, 0);
      total++; if (src_addr[69:65] !== 5'd7) $display("FAIL src_2_3: got %0d want 7", src_addr[69:65]); else passed++;
   endtask

   task automatic test_wait();
      @(negedge clk);
      rca_busy = 4'b0010;
      repeat (5) @(negedge clk);
      run_instr("grid_wait", 3'b010, 7'd1, 32'd71, 32'd5, 6);
      total++; if (grid_sel[431:429] !== 3'd5) $display("FAIL grid_1_71: got %0d want 5", grid_sel[431:429]); else passed++;
   endtask

   task automatic test_illegal();
      run_instr("ill_io_idx", 3'b011, 7'd0, 32'd13, 32'd1, 0);
      run_instr("ill_res_val", 3'b100, 7'd0, 32'd1, 32'd14, 0);
      run_instr("ill_f3_000", 3'b000, 7'd0, 32'd0, 32'd1, 0);
      run_instr("ill_f7_4", 3'b001, 7'd4, 32'd0, 32'd1, 0);
      run_instr("ill_grid_72", 3'b010, 7'd3, 32'd72, 32'd1, 0);
      run_instr("ill_src_5", 3'b001, 7'd3, 32'd5, 32'd1, 0);
   endtask

   task automatic test_res_io();
      run_instr("res_fb", 3'b100, 7'd0, 32'h0A, 32'd4, 0);
      total++;
      if ({res_sel_fb[11:8], res_sel_nfb[11:8]} !== {4'd4, 4'd13})
         $display("FAIL res_0_2: got fb=%0d nfb=%0d want fb=4 nfb=13", res_sel_fb[11:8], res_sel_nfb[11:8]);
      else passed++;
      run_instr("io_use", 3'b101, 7'd0, 32'h1FFF, 32'd0, 0);
      total++; if (io_use[12:0] !== 13'h1FFF) $display("FAIL io_use_0: got %h want 1fff", io_use[12:0]); else passed++;
   endtask

   task automatic test_flush();
      @(negedge clk);
      issue_valid = 1; issue_funct3 = 3'b011; issue_funct7 = 7'd3; issue_rs1 = 32'd5; issue_rs2 = 32'd9;
      rca_busy = 4'b1000;
      @(negedge clk);
      issue_valid = 0;
      @(negedge clk);
      flush = 1;
      #1;
      total++; if (cfg_done !== 1'b0) $display("FAIL flush_wait done: got %b want 0", cfg_done); else passed++;
      @(negedge clk);
      flush = 0; rca_busy = '0;
      #1;
      total++; if ({issue_ready, cfg_changed} !== 5'b10000) $display("FAIL flush_after: got %b want 10000", {issue_ready, cfg_changed}); else passed++;
      total++; if (act_all !== expected()) $display("FAIL flush_buses: bit %0d differs", first_diff(act_all, expected())); else passed++;
      // flush coincident with a handshake in IDLE must not lose the instruction
      issue_valid = 1; flush = 1; issue_funct3 = 3'b011; issue_funct7 = 7'd3; issue_rs1 = 32'd5; issue_rs2 = 32'd9;
      @(negedge clk);
      issue_valid = 0; flush = 0;
      #1;
      total++; if ({cfg_done, cfg_err} !== 2'b10) $display("FAIL flush_idle done/err: got %b%b want 10", cfg_done, cfg_err); else passed++;
      model_apply(3'b011, 7'd3, 32'd5, 32'd9);
      @(negedge clk);
      #1;
      total++; if (act_all !== expected()) $display("FAIL flush_idle buses: bit %0d differs", first_diff(act_all, expected())); else passed++;
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      logic [6:0] f7;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         issue_valid = 0;
         if (issue_ready) begin
            f7 = 7'($urandom_range(0, 3)); a = $urandom_range(0, 71); b = $urandom_range(0, 7);
            issue_valid = 1; issue_funct3 = 3'b010; issue_funct7 = f7; issue_rs1 = a; issue_rs2 = b;
            model_apply(3'b010, f7, a, b);
         end
         #1;
         if (cfg_done) dones++;
      end
      @(negedge clk);
      issue_valid = 0;
      #1;
      total++; if (dones !== 4) $display("FAIL b2b throughput: got %0d dones want 4", dones); else passed++;
      total++; if (act_all !== expected()) $display("FAIL b2b buses: bit %0d differs", first_diff(act_all, expected())); else passed++;
   endtask

   task automatic test_random();
      logic [2:0] f3;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = f3 == 3'd2 ? $urandom_range(0, 75) : f3 == 3'd3 ? $urandom_range(0, 15) : f3 == 3'd5 ? $urandom : $urandom_range(0, 31);
         b = f3 == 3'd1 ? $urandom : $urandom_range(0, 15);
         run_instr($sformatf("rand%0d", i), f3, 7'($urandom_range(0, 4)), a, b, $urandom_range(0, 3));
      end
   endtask

   task automatic test_reset_mid();
      run_instr("pre_reset", 3'b001, 7'd1, 32'h18, 32'd21, 0);
      @(negedge clk);
      issue_valid = 1; issue_funct3 = 3'b001; issue_funct7 = 7'd0; issue_rs1 = 32'd0; issue_rs2 = 32'd9;
      rca_busy = 4'b0001;
      @(negedge clk);
      issue_valid = 0;
      @(negedge clk);
      rst_n = 0;
      #1;
      model_reset();
      total++; if (act_all !== expected()) $display("FAIL mid_reset buses: bit %0d differs", first_diff(act_all, expected())); else passed++;
      total++;
      if ({issue_ready, cfg_done, cfg_changed} !== 6'b100000) $display("FAIL mid_reset ctrl: got %b want 100000", {issue_ready, cfg_done, cfg_changed});
      else passed++;
      @(negedge clk);
      rst_n = 1; rca_busy = '0;
      @(negedge clk);
      #1;
      total++;
      if ({cfg_done, cfg_changed} !== 5'b0) $display("FAIL post_reset ctrl: got %b want 00000", {cfg_done, cfg_changed});
      else passed++;
      total++; if (act_all !== expected()) $display("FAIL post_reset buses: bit %0d differs", first_diff(act_all, expected())); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait();
      test_illegal();
      test_res_io();
      test_flush();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/rca_config_unit.md
Name: rca_config_unit

Overview:
- Executes RCA configuration instructions (funct3 001-101) issued by the CPU decode/issue stage and holds every per-RCA configuration register: CPU port register addresses, grid MUX selects, IO-unit MUX selects, result MUX selects and IO input usage.
- Drives the flat configuration buses into the RCA grid/IO/result logic.
- Serialises writes so that a configuration change never lands on an RCA that is currently executing.

Parameters:
- NUM_RCAS, 4, number of RCAs (from rca_config).
- NUM_READ_PORTS, 5, source ports per RCA.
- NUM_WRITE_PORTS, 5, destination ports per RCA.
- NUM_GRID_MUXES, 72, grid MUXes per RCA.
- NUM_IO_UNITS, 13, IO units per RCA.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  config instruction offered.
- issue_ready  out  1  unit can accept.
- issue_funct3  in  3  instruction type.
- issue_funct7  in  7  target RCA id.
- issue_rs1  in  32  rs1 operand value.
- issue_rs2  in  32  rs2 operand value.
- rca_busy  in  NUM_RCAS  RCA n executing.
- flush  in  1  discard the held instruction.
- cfg_done  out  1  one-cycle completion pulse.
- cfg_err  out  1  qualifies cfg_done: instruction illegal, no write.
- cfg_changed  out  NUM_RCAS  one-cycle pulse per written RCA.
- src_addr  out  NUM_RCAS*NUM_READ_PORTS*5  source register addresses.
- dst_addr_fb  out  NUM_RCAS*NUM_WRITE_PORTS*5  feedback destination registers.
- dst_addr_nfb  out  NUM_RCAS*NUM_WRITE_PORTS*5  non-feedback destination registers.
- grid_sel  out  NUM_RCAS*NUM_GRID_MUXES*3  grid MUX selects.
- io_sel  out  NUM_RCAS*NUM_IO_UNITS*4  IO-unit MUX selects.
- res_sel_fb  out  NUM_RCAS*NUM_WRITE_PORTS*4  feedback result MUX selects.
- res_sel_nfb  out  NUM_RCAS*NUM_WRITE_PORTS*4  non-feedback result MUX selects.
- io_use  out  NUM_RCAS*NUM_IO_UNITS  IO input usage masks.

Behaviour:
- Reset values:
  - src_addr, dst_addr_*, grid_sel, io_sel and io_use are all 0.
  - res_sel_fb and res_sel_nfb are UNUSED_WRITE_PORT_ADDR (13).
  - cfg_done, cfg_err and cfg_changed are 0; FSM is in IDLE.
- FSM states: IDLE, CHECK, WAIT.
  - issue_ready = 1 only in IDLE.
  - issue_valid && issue_ready in IDLE latches funct3/funct7/rs1/rs2 into holding registers and moves to CHECK.
- CHECK legality; the instruction is illegal if any of the following holds:
  - funct7 >= NUM_RCAS, or funct3 is 000, 110 or 111.
  - 001: src with rs1[2:0] >= NUM_READ_PORTS, or dest with rs1[2:0] >= NUM_WRITE_PORTS.
  - 010: rs1 >= NUM_GRID_MUXES or rs2 >= 8.
  - 011: rs1 >= NUM_IO_UNITS or rs2 >= 12.
  - 100: rs1[2:0] >= NUM_WRITE_PORTS or rs2 > 13.
- CHECK outcomes:
  - Illegal: cfg_done=1 and cfg_err=1 in this cycle, no write, go to IDLE.
  - Legal and rca_busy[funct7]=1: go to WAIT.
  - Legal and not busy: commit the write at the clock edge ending CHECK, cfg_done=1, go to IDLE.
- WAIT: stay while rca_busy[funct7]. In the first cycle it is low, commit exactly as in CHECK.
- Commit decode by funct3:
  - 001: rs1[3]=0 writes src_addr[id][rs1[2:0]] = rs2[4:0]. rs1[3]=1 writes dst_addr_fb (rs1[4]=1) or dst_addr_nfb (rs1[4]=0).
  - 010: grid_sel[id][rs1] = rs2[2:0].
  - 011: io_sel[id][rs1] = rs2[3:0].
  - 100: rs1[3]=1 selects res_sel_fb, else res_sel_nfb; entry [rs1[2:0]] = rs2[3:0].
  - 101: io_use[id] = rs1[12:0].
- Timing:
  - Best-case latency: accept at cycle N, cfg_done at N+1, new value on the output bus at N+2.
  - cfg_changed[id] pulses at N+2, aligned with the new value.
  - Throughput: one instruction per 2 cycles.
- flush in CHECK or WAIT returns to IDLE with no write and no cfg_done. flush in IDLE has no effect; a same-cycle handshake is still accepted.
- Reset mid-operation discards the held instruction and restores every reset value.
- rca_busy of RCAs other than the target never stalls the unit.

Decomposition:
- Shared rca_config package gains:
  - funct3 opcode constants (RCA_USE_FB, CPU_REG_CFG, GRID_MUX_CFG, IO_MUX_CFG, RES_MUX_CFG, IO_USE_CFG, RCA_USE_NFB).
  - Select widths: GRID_SEL_W=3, IO_SEL_W=4, RES_SEL_W=4.
  - rca_cfg_instr_t struct.
- One sub-module, rca_config_legality: purely combinational legality check of the held instruction, returning an illegal flag.

Test Plan:
- After reset, check res_sel_fb and res_sel_nfb are all 13 and every other config output is 0. Issue 001 with funct7=2, rs1=0x03, rs2=7 -> cfg_done at N+1 with cfg_err=0, src_addr[2][3]=7 at N+2, cfg_changed=0b0100.
- rca_busy[1]=1 for 5 cycles, then issue 010 with funct7=1, rs1=71, rs2=5 -> unit holds in WAIT, no cfg_done while busy, commits in the first non-busy cycle, grid_sel[1][71]=5.
- Illegal cases: 011 with rs1=13; 100 with rs2=14; funct3=000; funct7=4 -> each gives cfg_done+cfg_err and no output change.
- 100 with funct7=0, rs1=0x0A, rs2=4 -> res_sel_fb[0][2]=4 with res_sel_nfb unchanged. Then 101 with rs1=0x1FFF -> io_use[0]=0x1FFF.
- Assert flush while in WAIT -> no write, no cfg_done, issue_ready=1 the next cycle.
- Assert rst_n low while in WAIT after one prior commit -> all outputs return to reset values and the FSM returns to IDLE.
